dcache_data_arb: RTL and testbench

DCACHE_DATA_ARB -- requirements
Module: dcache_data_arb

---
 rtl/dcache_data_arb_pkg.sv | 25 ++
 rtl/dcache_data_arb_if.sv | 37 +++
 rtl/dcache_store_buf.sv | 69 ++++++
 rtl/dcache_data_arb.sv | 167 ++++++++++++++++
 tb/tb_dcache_data_arb.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dcache_data_arb_pkg.sv
// Shared types for the D-cache data-array arbiter: store-buffer entry, FSM
// states and the line/word split of the word address.
package dcache_data_arb_pkg;

    localparam int LINE_IDX_W  = 7;
    localparam int WORD_IDX_W  = 3;
    localparam int WORD_ADDR_W = LINE_IDX_W + WORD_IDX_W;

    typedef struct packed {
        logic [WORD_ADDR_W-1:0] addr;
        logic [31:0]            data;
        logic [3:0]             ben;
    } sb_entry_t;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } arb_state_e;

    function automatic logic [LINE_IDX_W-1:0] line_of(input logic [WORD_ADDR_W-1:0] addr);
        return addr[WORD_ADDR_W-1:WORD_IDX_W];
    endfunction

endpackage

// File: rtl/dcache_data_arb_if.sv
// Requester-side bus of the data-array arbiter: load, store, refill and flush
// handshakes plus the load response.
interface dcache_data_arb_if
    import dcache_data_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int LINE_WIDTH = 256
);
    logic                  ld_valid;
    logic                  ld_ready;
    logic [ADDR_WIDTH-1:0] ld_addr;
    logic                  rdata_valid;
    logic [31:0]           rdata;
    logic                  st_valid;
    logic                  st_ready;
    logic [ADDR_WIDTH-1:0] st_addr;
    logic [31:0]           st_data;
    logic [3:0]            st_ben;
    logic                  rf_valid;
    logic                  rf_ready;
    logic [LINE_IDX_W-1:0] rf_index;
    logic [LINE_WIDTH-1:0] rf_line;
    logic                  flush_req;
    logic                  flush_done;

    modport master (
        output ld_valid, ld_addr, st_valid, st_addr, st_data, st_ben,
               rf_valid, rf_index, rf_line, flush_req,
        input  ld_ready, rdata_valid, rdata, st_ready, rf_ready, flush_done
    );

    modport slave (
        input  ld_valid, ld_addr, st_valid, st_addr, st_data, st_ben,
               rf_valid, rf_index, rf_line, flush_req,
        output ld_ready, rdata_valid, rdata, st_ready, rf_ready, flush_done
    );
endinterface

// File: rtl/dcache_store_buf.sv
// Store buffer: shift-style FIFO (entry 0 is always the oldest) with occupancy
// and per-entry word-address / line-index match vectors.
module dcache_store_buf
    import dcache_data_arb_pkg::*;
#(
    parameter int SB_DEPTH = 2
) (
    input  logic                             clk,
    input  logic                             resetn,
    input  logic                             enq,
    input  sb_entry_t                        enq_entry,
    input  logic                             deq,
    output sb_entry_t [SB_DEPTH-1:0]         entries,
    output logic [$clog2(SB_DEPTH+1)-1:0]    count,
    output logic                             full,
    output logic                             empty,
    input  logic [WORD_ADDR_W-1:0]           ld_addr,
    output logic [SB_DEPTH-1:0]              ld_match,
    input  logic [LINE_IDX_W-1:0]            rf_index,
    output logic [SB_DEPTH-1:0]              rf_match
);
    localparam int CNT_W = $clog2(SB_DEPTH + 1);

    sb_entry_t [SB_DEPTH-1:0] ent_r;
    logic [CNT_W-1:0]         count_r;
    logic [CNT_W-1:0]         wr_idx_s;

    // A simultaneous dequeue shifts everything down, so the new entry lands one slot lower.
    assign wr_idx_s = deq ? (count_r - CNT_W'(1)) : count_r;

    // Occupancy counter.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            count_r <= '0;
        end else begin
            count_r <= count_r + CNT_W'(enq) - CNT_W'(deq);
        end
    end

    // Entry storage; validity is carried by count_r so the payload needs no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < SB_DEPTH - 1; i++) begin
            if (deq) begin
                ent_r[i] <= ent_r[i+1];
            end
        end
        for (int i = 0; i < SB_DEPTH; i++) begin
            if (enq && (wr_idx_s == CNT_W'(i))) begin
                ent_r[i] <= enq_entry;
            end
        end
    end

    // Per-entry match against the load word address and the refill line index.
    always_comb begin
        ld_match = '0;
        rf_match = '0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            ld_match[i] = (CNT_W'(i) < count_r) && (ent_r[i].addr == ld_addr);
            rf_match[i] = (CNT_W'(i) < count_r) && (line_of(ent_r[i].addr) == rf_index);
        end
    end

    assign entries = ent_r;
    assign count   = count_r;
    assign full    = (count_r == CNT_W'(SB_DEPTH));
    assign empty   = (count_r == '0);

endmodule

// File: rtl/dcache_data_arb.sv
// Single-port D-cache data-array arbiter: refill > full-buffer drain > load > drain,
// with a RUN/DRAIN/DONE flush FSM. Optional store-to-load forwarding: DCACHE_ST_FWD_EN.
module dcache_data_arb
    import dcache_data_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int SB_DEPTH   = 2,
    parameter int LINE_WIDTH = 256
) (
    input  logic                  clk,
    input  logic                  resetn,
    dcache_data_arb_if.slave      bus,
    output logic [ADDR_WIDTH-1:0] ram_raddr,
    output logic [ADDR_WIDTH-1:0] ram_waddr,
    output logic                  ram_re,
    output logic                  ram_we,
    output logic                  ram_store,
    output logic                  ram_hit_write,
    output logic [31:0]           ram_din,
    output logic [3:0]            ram_byte_ben,
    output logic [LINE_WIDTH-1:0] ram_din_all,
    input  logic [31:0]           ram_dout
);
    localparam int CNT_W = $clog2(SB_DEPTH + 1);

    arb_state_e               state_r, state_s;
    sb_entry_t [SB_DEPTH-1:0] sb_ent_s;
    sb_entry_t                head_s, enq_entry_s;
    logic [CNT_W-1:0]         sb_count_s;
    logic                     sb_full_s, sb_empty_s;
    logic [SB_DEPTH-1:0]      ld_match_s, rf_match_s;
    logic                     rf_ready_s, rf_fire_s, ld_ready_s, ld_fire_s;
    logic                     st_ready_s, enq_s, drain_s, ld_block_s;
    logic                     rdata_valid_r;
    logic [31:0]              rdata_s;

    assign enq_entry_s = '{addr: bus.st_addr, data: bus.st_data, ben: bus.st_ben};
    assign head_s      = sb_ent_s[0];

    dcache_store_buf #(.SB_DEPTH(SB_DEPTH)) u_sb (
        .clk       (clk),
        .resetn    (resetn),
        .enq       (enq_s),
        .enq_entry (enq_entry_s),
        .deq       (drain_s),
        .entries   (sb_ent_s),
        .count     (sb_count_s),
        .full      (sb_full_s),
        .empty     (sb_empty_s),
        .ld_addr   (bus.ld_addr),
        .ld_match  (ld_match_s),
        .rf_index  (bus.rf_index),
        .rf_match  (rf_match_s)
    );

    // Issue arbitration: one array access per cycle; a load never sees a store accepted alongside it.
    always_comb begin
        rf_ready_s = resetn && !(|rf_match_s);
        rf_fire_s  = bus.rf_valid && rf_ready_s;
        ld_ready_s = resetn && (state_r == ST_RUN) && !rf_fire_s && !sb_full_s && !ld_block_s;
        ld_fire_s  = bus.ld_valid && ld_ready_s;
        drain_s    = resetn && !rf_fire_s && !sb_empty_s && !ld_fire_s;
        st_ready_s = resetn && (state_r == ST_RUN) && !sb_full_s;
        enq_s      = bus.st_valid && st_ready_s;
    end

    // Flush FSM state register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_s;
        end
    end

    // Flush FSM next state; DRAIN exits as soon as the buffer becomes empty.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (bus.flush_req) state_s = ST_DRAIN;
                else               state_s = ST_RUN;
            end
            ST_DRAIN: begin
                if (sb_empty_s || ((sb_count_s == CNT_W'(1)) && drain_s)) state_s = ST_DONE;
                else                                                       state_s = ST_DRAIN;
            end
            ST_DONE: state_s = ST_RUN;
            default: state_s = ST_RUN;
        endcase
    end

    // Load response is valid exactly one cycle after accept.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rdata_valid_r <= 1'b0;
        end else begin
            rdata_valid_r <= ld_fire_s;
        end
    end

`ifdef DCACHE_ST_FWD_EN
    logic [31:0] fwd_data_s, fwd_data_r;
    logic [3:0]  fwd_mask_s, fwd_mask_r;

    // Merge matching buffered bytes oldest to youngest so the youngest write wins.
    always_comb begin
        fwd_data_s = 32'h0000_0000;
        fwd_mask_s = 4'b0000;
        for (int i = 0; i < SB_DEPTH; i++) begin
            for (int b = 0; b < 4; b++) begin
                fwd_data_s[8*b +: 8] = (ld_match_s[i] && sb_ent_s[i].ben[b]) ?
                                       sb_ent_s[i].data[8*b +: 8] : fwd_data_s[8*b +: 8];
                fwd_mask_s[b]        = fwd_mask_s[b] | (ld_match_s[i] && sb_ent_s[i].ben[b]);
            end
        end
    end

    // Forwarding state is frozen at load accept; later drains must not alter the response.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            fwd_data_r <= 32'h0000_0000;
            fwd_mask_r <= 4'b0000;
        end else if (ld_fire_s) begin
            fwd_data_r <= fwd_data_s;
            fwd_mask_r <= fwd_mask_s;
        end else begin
            fwd_data_r <= fwd_data_r;
            fwd_mask_r <= fwd_mask_r;
        end
    end

    // Response byte mux between the array word and forwarded bytes.
    always_comb begin
        rdata_s = ram_dout;
        for (int b = 0; b < 4; b++) begin
            rdata_s[8*b +: 8] = fwd_mask_r[b] ? fwd_data_r[8*b +: 8] : ram_dout[8*b +: 8];
        end
    end

    assign ld_block_s = 1'b0;
`else
    logic sb_ent_unused_s;

    assign sb_ent_unused_s = ^sb_ent_s;
    assign ld_block_s      = |ld_match_s;
    assign rdata_s         = ram_dout;
`endif

    assign bus.ld_ready    = ld_ready_s;
    assign bus.st_ready    = st_ready_s;
    assign bus.rf_ready    = rf_ready_s;
    assign bus.rdata_valid = resetn && rdata_valid_r;
    assign bus.rdata       = rdata_s;
    assign bus.flush_done  = resetn && (state_r == ST_DONE);

    assign ram_re        = ld_fire_s;
    assign ram_raddr     = bus.ld_addr;
    assign ram_we        = rf_fire_s || drain_s;
    assign ram_store     = drain_s;
    assign ram_hit_write = rf_fire_s;
    assign ram_waddr     = rf_fire_s ? {bus.rf_index, 3'b000} : head_s.addr;
    assign ram_din       = head_s.data;
    assign ram_byte_ben  = drain_s ? head_s.ben : 4'b0000;
    assign ram_din_all   = bus.rf_line;

endmodule

// File: tb/tb_dcache_data_arb.sv
// Scoreboard bench for dcache_data_arb: stimulus pushes expected load data and
// array writes; monitors pop and compare on the falling edge.
module tb_dcache_data_arb;
    localparam int AW = 10;
    localparam int LW = 256;

    typedef struct {
        logic           hit;
        logic [AW-1:0]  addr;
        logic [31:0]    data;
        logic [3:0]     ben;
        logic [LW-1:0]  line;
    } wr_t;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    dcache_data_arb_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) bus ();

    logic [AW-1:0] ram_raddr, ram_waddr;
    logic          ram_re, ram_we, ram_store, ram_hit_write;
    logic [31:0]   ram_din, ram_dout;
    logic [3:0]    ram_byte_ben;
    logic [LW-1:0] ram_din_all;

    dcache_data_arb #(.ADDR_WIDTH(AW), .SB_DEPTH(2), .LINE_WIDTH(LW)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .bus           (bus),
        .ram_raddr     (ram_raddr),
        .ram_waddr     (ram_waddr),
        .ram_re        (ram_re),
        .ram_we        (ram_we),
        .ram_store     (ram_store),
        .ram_hit_write (ram_hit_write),
        .ram_din       (ram_din),
        .ram_byte_ben  (ram_byte_ben),
        .ram_din_all   (ram_din_all),
        .ram_dout      (ram_dout)
    );

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] exp_rd_q [$];
    wr_t         exp_wr_q [$];
    logic [31:0] mem [0:1023];
    logic [LW-1:0] rf_line_v;

    function automatic logic [31:0] pat(input int a);
        return 32'hA500_0000 | 32'(a);
    endfunction

    // Data-array model: reset restores the background pattern.
    always @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < 1024; i++) mem[i] <= pat(i);
            ram_dout <= 32'h0;
        end else begin
            if (ram_re) ram_dout <= mem[ram_raddr];
            if (ram_we && ram_store)
                for (int b = 0; b < 4; b++)
                    if (ram_byte_ben[b]) mem[ram_waddr][8*b +: 8] <= ram_din[8*b +: 8];
            if (ram_we && ram_hit_write)
                for (int w = 0; w < 8; w++)
                    mem[{ram_waddr[9:3], w[2:0]}] <= ram_din_all[32*w +: 32];
        end
    end

    // Monitors: pop the expected response / write whenever the DUT presents one.
    always @(negedge clk) begin
        logic [31:0] e;
        wr_t w;
        if (bus.rdata_valid) begin
            vectors++;
            if (exp_rd_q.size() == 0) begin
                miscompares++;
                $display("FAIL rdata_unexpected: got %h, expected no response", bus.rdata);
            end else begin
                e = exp_rd_q.pop_front();
                if (bus.rdata !== e) begin
                    miscompares++;
                    $display("FAIL rdata: got %h, expected %h", bus.rdata, e);
                end
            end
        end
        if (ram_we) begin
            vectors++;
            if (exp_wr_q.size() == 0) begin
                miscompares++;
                $display("FAIL write_unexpected: got waddr %h hit %b store %b, expected no write",
                         ram_waddr, ram_hit_write, ram_store);
            end else begin
                w = exp_wr_q.pop_front();
                if (ram_hit_write !== w.hit || ram_store !== !w.hit || ram_waddr !== w.addr ||
                    (w.hit ? (ram_din_all !== w.line) : (ram_din !== w.data || ram_byte_ben !== w.ben))) begin
                    miscompares++;
                    $display("FAIL write: got hit %b store %b waddr %h din %h ben %b, expected hit %b waddr %h din %h ben %b",
                             ram_hit_write, ram_store, ram_waddr, ram_din, ram_byte_ben,
                             w.hit, w.addr, w.data, w.ben);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic set_st(input logic v, input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be);
        bus.st_valid = v; bus.st_addr = a; bus.st_data = d; bus.st_ben = be;
    endtask

    task automatic set_ld(input logic v, input logic [AW-1:0] a);
        bus.ld_valid = v; bus.ld_addr = a;
    endtask

    task automatic exp_st(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be);
        exp_wr_q.push_back('{hit: 1'b0, addr: a, data: d, ben: be, line: '0});
    endtask

    initial begin
        for (int w = 0; w < 8; w++) rf_line_v[32*w +: 32] = 32'hC0DE_0010 + 32'(w);
        resetn = 1'b0;
        set_st(1'b1, 10'h005, 32'h0, 4'hF);
        set_ld(1'b1, 10'h005);
        bus.rf_valid = 1'b1; bus.rf_index = 7'd0; bus.rf_line = rf_line_v;
        bus.flush_req = 1'b0;
        repeat (3) tick();
        chk1("rst_st_ready", bus.st_ready, 1'b0);
        chk1("rst_ld_ready", bus.ld_ready, 1'b0);
        chk1("rst_rf_ready", bus.rf_ready, 1'b0);
        chk1("rst_ram_re", ram_re, 1'b0);
        chk1("rst_ram_we", ram_we, 1'b0);
        chk1("rst_rdata_valid", bus.rdata_valid, 1'b0);
        chk1("rst_flush_done", bus.flush_done, 1'b0);
        set_st(1'b0, 10'h0, 32'h0, 4'h0); set_ld(1'b0, 10'h0); bus.rf_valid = 1'b0;
        tick();
        resetn = 1'b1;
        tick();
        chk1("idle_st_ready", bus.st_ready, 1'b1);
        chk1("idle_ld_ready", bus.ld_ready, 1'b1);

        // Store then load to the same word.
        set_st(1'b1, 10'h012, 32'h1122_3344, 4'b0011); settle();
        chk1("a_st_ready", bus.st_ready, 1'b1);
        tick();
        set_st(1'b0, 10'h0, 32'h0, 4'h0); set_ld(1'b1, 10'h012); settle();
`ifdef DCACHE_ST_FWD_EN
        chk1("a_fwd_ld_ready", bus.ld_ready, 1'b1);
        exp_rd_q.push_back(32'hA500_3344);
        tick();
        set_ld(1'b0, 10'h0);
        exp_st(10'h012, 32'h1122_3344, 4'b0011);
        tick();
`else
        chk1("a_nofwd_ld_blocked", bus.ld_ready, 1'b0);
        exp_st(10'h012, 32'h1122_3344, 4'b0011);
        tick(); settle();
        chk1("a_nofwd_ld_after_drain", bus.ld_ready, 1'b1);
        exp_rd_q.push_back(32'hA500_3344);
        tick();
        set_ld(1'b0, 10'h0);
`endif
        repeat (2) tick();

        // Refill blocked by a buffered store to the same line.
        set_st(1'b1, 10'h013, 32'hDEAD_BEEF, 4'hF); tick();
        set_st(1'b0, 10'h0, 32'h0, 4'h0);
        bus.rf_valid = 1'b1; bus.rf_index = 7'd2; bus.rf_line = rf_line_v;
        set_ld(1'b1, 10'h100); settle();
        chk1("b_rf_blocked_0", bus.rf_ready, 1'b0);
        exp_rd_q.push_back(pat(32'h100));
        tick(); set_ld(1'b1, 10'h101); settle();
        chk1("b_rf_blocked_1", bus.rf_ready, 1'b0);
        exp_rd_q.push_back(pat(32'h101));
        tick(); set_ld(1'b0, 10'h0); settle();
        chk1("b_rf_blocked_drain", bus.rf_ready, 1'b0);
        exp_st(10'h013, 32'hDEAD_BEEF, 4'hF);
        tick(); settle();
        chk1("b_rf_ready", bus.rf_ready, 1'b1);
        exp_wr_q.push_back('{hit: 1'b1, addr: 10'h010, data: 32'h0, ben: 4'h0, line: rf_line_v});
        tick(); bus.rf_valid = 1'b0;
        tick();

        // Full buffer: drain preempts the load stream, third store follows the drain.
        set_st(1'b1, 10'h020, 32'h0000_AAAA, 4'hF); set_ld(1'b1, 10'h040); settle();
        chk1("c_ld_ready_0", bus.ld_ready, 1'b1);
        exp_rd_q.push_back(pat(32'h040));
        tick(); set_st(1'b1, 10'h021, 32'h0000_BBBB, 4'hF); set_ld(1'b1, 10'h041); settle();
        chk1("c_st_ready_1", bus.st_ready, 1'b1);
        exp_rd_q.push_back(pat(32'h041));
        tick(); set_st(1'b1, 10'h022, 32'h0000_CCCC, 4'hF); set_ld(1'b1, 10'h042); settle();
        chk1("c_full_st_ready", bus.st_ready, 1'b0);
        chk1("c_full_ld_preempted", bus.ld_ready, 1'b0);
        exp_st(10'h020, 32'h0000_AAAA, 4'hF);
        tick(); settle();
        chk1("c_third_store_accept", bus.st_ready, 1'b1);
        chk1("c_ld_resumes", bus.ld_ready, 1'b1);
        exp_rd_q.push_back(pat(32'h042));
        tick(); set_st(1'b0, 10'h0, 32'h0, 4'h0); set_ld(1'b1, 10'h043); settle();
        chk1("c_full_again_ld", bus.ld_ready, 1'b0);
        exp_st(10'h021, 32'h0000_BBBB, 4'hF);
        tick(); settle();
        exp_rd_q.push_back(pat(32'h043));
        tick(); set_ld(1'b0, 10'h0); settle();
        exp_st(10'h022, 32'h0000_CCCC, 4'hF);
        repeat (2) tick();

        // Flush with two buffered entries.
        set_st(1'b1, 10'h030, 32'h4444_0000, 4'b1100); set_ld(1'b1, 10'h050); settle();
        exp_rd_q.push_back(pat(32'h050));
        tick(); set_st(1'b1, 10'h031, 32'h0000_0055, 4'b0001); set_ld(1'b1, 10'h051);
        bus.flush_req = 1'b1; settle();
        exp_rd_q.push_back(pat(32'h051));
        tick(); set_st(1'b0, 10'h0, 32'h0, 4'h0); set_ld(1'b1, 10'h052); bus.flush_req = 1'b0; settle();
        chk1("d_drain_ld_blocked_0", bus.ld_ready, 1'b0);
        chk1("d_drain_st_blocked", bus.st_ready, 1'b0);
        chk1("d_flush_done_0", bus.flush_done, 1'b0);
        exp_st(10'h030, 32'h4444_0000, 4'b1100);
        tick(); settle();
        chk1("d_drain_ld_blocked_1", bus.ld_ready, 1'b0);
        chk1("d_flush_done_1", bus.flush_done, 1'b0);
        exp_st(10'h031, 32'h0000_0055, 4'b0001);
        tick(); settle();
        chk1("d_flush_done_pulse", bus.flush_done, 1'b1);
        chk1("d_done_ld_blocked", bus.ld_ready, 1'b0);
        tick(); settle();
        chk1("d_flush_done_clear", bus.flush_done, 1'b0);
        chk1("d_run_ld_ready", bus.ld_ready, 1'b1);
        exp_rd_q.push_back(pat(32'h052));
        tick(); set_ld(1'b0, 10'h0);
        tick();

        // Reset the cycle after a load accept, with a store pending.
        set_st(1'b1, 10'h070, 32'h6666_6666, 4'hF); set_ld(1'b1, 10'h060); settle();
        chk1("e_ld_ready", bus.ld_ready, 1'b1);
        tick(); set_st(1'b0, 10'h0, 32'h0, 4'h0); set_ld(1'b0, 10'h0); resetn = 1'b0; settle();
        chk1("e_rst_rdata_valid", bus.rdata_valid, 1'b0);
        tick(); resetn = 1'b1; set_ld(1'b1, 10'h070); settle();
        chk1("e_st_ready_after_rst", bus.st_ready, 1'b1);
        chk1("e_no_drain_after_rst", ram_we, 1'b0);
        chk1("e_ld_ready_after_rst", bus.ld_ready, 1'b1);
        exp_rd_q.push_back(pat(32'h070));
        tick(); set_ld(1'b0, 10'h0); settle();
        chk1("e_no_drain_later", ram_we, 1'b0);
        repeat (3) tick();

        chk1("rd_queue_drained", exp_rd_q.size() == 0, 1'b1);
        chk1("wr_queue_drained", exp_wr_q.size() == 0, 1'b1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
